// File: rtl/recur_sched_pkg.sv
// Shared definitions for the recurrence job scheduler: FSM encoding,
// iteration limit and default length-field width.
package recur_sched_pkg;

    localparam int MAXLEN   = 99;
    localparam int LENW_DEF = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // The datapath cannot run more than MAXLEN iterations.
    function automatic int sat_len(input int len);
        return (len > MAXLEN) ? MAXLEN : len;
    endfunction

endpackage

// File: rtl/recur_sched_if.sv
// Job-request and datapath signals of the recurrence scheduler.
interface recur_sched_if
    import recur_sched_pkg::*;
#(
    parameter int W    = 32,
    parameter int LENW = LENW_DEF
);
    logic [1:0]      req;
    logic [W-1:0]    x0;
    logic [W-1:0]    x1;
    logic [LENW-1:0] len0;
    logic [LENW-1:0] len1;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [W-1:0]    y;
    logic            busy;
    logic            dp_clr;
    logic            dp_en;
    logic [W-1:0]    dp_x;
    logic [W-1:0]    dp_y;

    // master: requesters plus the external datapath; slave: the scheduler
    modport master (
        output req, x0, x1, len0, len1, dp_y,
        input  gnt, done, y, busy, dp_clr, dp_en, dp_x
    );

    modport slave (
        input  req, x0, x1, len0, len1, dp_y,
        output gnt, done, y, busy, dp_clr, dp_en, dp_x
    );
endinterface

// File: rtl/recur_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted
// requester so that, under contention, the other one wins next.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic last_reg;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_reg ? 2'b01 : 2'b10;
        end
    end

    // Reset to "last was 1" so the first grant goes to requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_reg <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last_reg <= gnt[1];
        end
    end
endmodule

// File: rtl/recur_sched.sv
// Scheduler that grants one of two requesters and sequences an external
// recurrence datapath through clear, len iterations and result capture.
module recur_sched
    import recur_sched_pkg::*;
#(
    parameter int W    = 32,
    parameter int LENW = LENW_DEF
) (
    input logic          clk,
    input logic          rst,
    recur_sched_if.slave bus
);
    state_t          state_reg, state_next;
    logic [LENW-1:0] cnt_reg;
    logic [LENW-1:0] len_reg;
    logic [LENW-1:0] len_sel;
    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic            sel_reg;
    logic [1:0]      arb_gnt;
    logic            take;
    logic            last_iter;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .accept (take),
        .gnt    (arb_gnt)
    );

    assign take      = (state_reg == IDLE) && (bus.req != 2'b00);
    assign len_sel   = arb_gnt[1] ? bus.len1 : bus.len0;
    assign last_iter = (cnt_reg == len_reg - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take) state_next = CLEAR;
            CLEAR:   state_next = (len_reg == '0) ? DRAIN : RUN;
            RUN:     if (last_iter) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // gnt is combinational in IDLE; it is also masked while reset is held.
    always_comb begin
        bus.gnt    = (take && rst) ? arb_gnt : 2'b00;
        bus.busy   = (state_reg != IDLE);
        bus.dp_clr = (state_reg == CLEAR);
        bus.dp_en  = (state_reg == RUN);
        bus.done   = 2'b00;
        if (state_reg == DONE) begin
            bus.done = sel_reg ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg   <= '0;
            len_reg <= '0;
            cnt_reg <= '0;
            y_reg   <= '0;
            sel_reg <= 1'b0;
        end else begin
            if (take) begin
                x_reg   <= arb_gnt[1] ? bus.x1 : bus.x0;
                len_reg <= LENW'(sat_len(int'(len_sel)));
                sel_reg <= arb_gnt[1];
            end
            if (state_reg == CLEAR) begin
                cnt_reg <= '0;
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == DRAIN) begin
                y_reg <= bus.dp_y;
            end
        end
    end

    assign bus.dp_x = x_reg;
    assign bus.y    = y_reg;
endmodule
